// File: rtl/count_reader_pkg.sv
// Shared types and constants for the FIFO counter reader.
package count_reader_pkg;

    localparam int TIMEOUT_DEF = 8;
    localparam int CNT_W       = 5;
    localparam int TOT_W       = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [TOT_W-1:0] sum4(
        input logic [3:0][CNT_W-1:0] c
    );
        return {2'b00, c[0]} + {2'b00, c[1]}
             + {2'b00, c[2]} + {2'b00, c[3]};
    endfunction

endpackage

// File: rtl/count_reader_wait_timer.sv
// Response wait timer: cleared per request, terminal count at TIMEOUT-1.
module wait_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == 4'(TIMEOUT - 1));

endmodule

// File: rtl/count_reader.sv
// Reads the four FIFO counters in turn through a req/valid responder.
module count_reader
    import count_reader_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             valid_in,
    input  logic [CNT_W-1:0] data_in,
    output logic             req,
    output logic [1:0]       idx,
    output logic [CNT_W-1:0] cnt_0,
    output logic [CNT_W-1:0] cnt_1,
    output logic [CNT_W-1:0] cnt_2,
    output logic [CNT_W-1:0] cnt_3,
    output logic [TOT_W-1:0] total,
    output logic             done,
    output logic             busy,
    output logic [3:0]       timeout_err
);

    state_t                  state, state_nx;
    logic                    tmr_clr, tmr_en, tmr_tc;
    logic [3:0][CNT_W-1:0]   cnt_q;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .tc      (tmr_tc)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req      = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_REQ;
            end
            S_REQ: begin
                req      = 1'b1;
                tmr_clr  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                req = 1'b1;
                if (valid_in || tmr_tc) state_nx = S_GAP;
                else                    tmr_en   = 1'b1;
            end
            S_GAP: begin
                state_nx = (idx == 2'd3) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Valid on the terminal-count cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idx         <= '0;
            cnt_q       <= '0;
            total       <= '0;
            timeout_err <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                idx         <= '0;
                cnt_q       <= '0;
                total       <= '0;
                timeout_err <= '0;
            end
        end else if (state == S_WAIT) begin
            if (valid_in) begin
                cnt_q[idx] <= data_in;
            end else if (tmr_tc) begin
                cnt_q[idx]       <= '0;
                timeout_err[idx] <= 1'b1;
            end
        end else if (state == S_GAP) begin
            if (idx == 2'd3) total <= sum4(cnt_q);
            else             idx   <= idx + 2'd1;
        end
    end

    assign cnt_0 = cnt_q[0];
    assign cnt_1 = cnt_q[1];
    assign cnt_2 = cnt_q[2];
    assign cnt_3 = cnt_q[3];

endmodule

// File: tb/tb_count_reader.sv
// Self-checking bench for count_reader with a latency-programmable responder.
module tb_count_reader;

    localparam int T = 8;

    typedef struct packed {
        logic [3:0][3:0] lat;
        logic [3:0][4:0] d;
        logic            alw;
        logic            rs;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       start;
    logic       valid_in;
    logic [4:0] data_in;
    logic       req;
    logic [1:0] idx;
    logic [4:0] cnt_0, cnt_1, cnt_2, cnt_3;
    logic [6:0] total;
    logic       done, busy;
    logic [3:0] timeout_err;

    logic [3:0][3:0] cfg_lat;
    logic [3:0][4:0] cfg_d;
    logic            cfg_alw;

    int n_chk  = 0;
    int n_fail = 0;

    count_reader #(.TIMEOUT(T)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .req         (req),
        .idx         (idx),
        .cnt_0       (cnt_0),
        .cnt_1       (cnt_1),
        .cnt_2       (cnt_2),
        .cnt_3       (cnt_3),
        .total       (total),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    // Responder: lat = WAIT cycle number carrying valid; 0 = stale pulse
    // during REQ only; >T = never answers in time.
    initial begin
        int age;
        age      = 0;
        valid_in = 1'b0;
        data_in  = '0;
        cfg_lat  = '0;
        cfg_d    = '0;
        cfg_alw  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (req) age++;
            else     age = 0;
            if (cfg_alw) valid_in = 1'b1;
            else valid_in = req && (age == int'(cfg_lat[idx]) + 1);
            data_in = cfg_d[idx];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0: return int'(cnt_0);
            1: return int'(cnt_1);
            2: return int'(cnt_2);
            default: return int'(cnt_3);
        endcase
    endfunction

    function automatic vec_t mk(input int l0, input int l1, input int l2,
                                input int l3, input int d0, input int d1,
                                input int d2, input int d3,
                                input bit alw, input bit rs);
        vec_t v;
        v.lat[0] = 4'(l0);
        v.lat[1] = 4'(l1);
        v.lat[2] = 4'(l2);
        v.lat[3] = 4'(l3);
        v.d[0]   = 5'(d0);
        v.d[1]   = 5'(d1);
        v.d[2]   = 5'(d2);
        v.d[3]   = 5'(d3);
        v.alw    = alw;
        v.rs     = rs;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " req"}, int'(req), 0);
        chk({tag, " idx"}, int'(idx), 0);
        chk({tag, " cnt_sum"},
            int'(cnt_0) + int'(cnt_1) + int'(cnt_2) + int'(cnt_3), 0);
        chk({tag, " total"}, int'(total), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " terr"}, int'(timeout_err), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int  w[4];
        int  ecnt[4];
        int  rq[4];
        int  exp_done, etot, eterr, done_at, dones;
        exp_done = 0;
        etot     = 0;
        eterr    = 0;
        for (int i = 0; i < 4; i++) begin
            int l;
            l     = int'(v.lat[i]);
            rq[i] = 0;
            if (v.alw || (l >= 1 && l <= T)) begin
                w[i]    = v.alw ? 1 : l;
                ecnt[i] = int'(v.d[i]);
            end else begin
                w[i]    = T;
                ecnt[i] = 0;
                eterr   = eterr | (1 << i);
            end
            etot     += ecnt[i];
            exp_done += 2 + w[i];
        end
        cfg_lat = v.lat;
        cfg_d   = v.d;
        cfg_alw = v.alw;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " first busy"}, int'(busy), 1);
        chk({tag, " first req"}, int'(req), 1);
        chk({tag, " first idx"}, int'(idx), 0);
        chk({tag, " cleared total"}, int'(total), 0);
        chk({tag, " cleared terr"}, int'(timeout_err), 0);
        chk({tag, " cleared cnt"},
            int'(cnt_0) + int'(cnt_1) + int'(cnt_2) + int'(cnt_3), 0);
        if (req) rq[idx]++;
        done_at = -1;
        dones   = 0;
        for (int c = 1; c <= exp_done + 20; c++) begin
            @(posedge clk);
            #1;
            if (req) rq[idx]++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            start = (v.rs && c == 5);
        end
        start = 1'b0;
        chk({tag, " done cycle"}, done_at, exp_done);
        chk({tag, " done pulses"}, dones, 1);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " total"}, int'(total), etot);
        chk({tag, " terr"}, int'(timeout_err), eterr);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s cnt_%0d", tag, i), get_cnt(i), ecnt[i]);
            chk($sformatf("%s req cycles %0d", tag, i), rq[i], 1 + w[i]);
        end
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = mk(1, 1, 1, 1, 3, 7, 0, 31, 1'b0, 1'b0);
        tbl[1] = mk(1, 1, 15, 1, 5, 6, 9, 10, 1'b0, 1'b0);
        tbl[2] = mk(0, 0, 0, 0, 1, 2, 3, 4, 1'b1, 1'b0);
        tbl[3] = mk(1, 1, 1, 1, 31, 31, 31, 31, 1'b0, 1'b1);
        tbl[4] = mk(8, 0, 7, 9, 11, 12, 13, 14, 1'b0, 1'b0);
        tbl[5] = mk(2, 3, 4, 5, 0, 1, 30, 29, 1'b0, 1'b1);

        reset_L = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_L = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(tbl[k], $sformatf("tbl%0d", k));
        end

        // Abort during the idx 1 wait; counts already captured must clear.
        cfg_lat = mk(1, 15, 1, 1, 3, 7, 0, 31, 1'b0, 1'b0).lat;
        cfg_d   = mk(1, 15, 1, 1, 3, 7, 0, 31, 1'b0, 1'b0).d;
        cfg_alw = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid req", int'(req), 1);
        chk("mid idx", int'(idx), 1);
        chk("mid cnt_0", int'(cnt_0), 3);
        reset_L = 1'b0;
        #1;
        check_zero("async rst");
        begin
            int dn;
            dn = 0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (done) dn++;
            end
            reset_L = 1'b1;
            repeat (6) begin
                @(posedge clk);
                #1;
                if (done || busy) dn++;
            end
            chk("post rst quiet", dn, 0);
        end
        run_vec(tbl[0], "after rst");

        for (int r = 0; r < 25; r++) begin
            vec_t v;
            for (int i = 0; i < 4; i++) begin
                int x;
                x        = int'($urandom_range(0, 10));
                v.lat[i] = (x > 8) ? 4'd15 : 4'(x);
                v.d[i]   = 5'($urandom_range(0, 31));
            end
            v.alw = ($urandom_range(0, 5) == 0);
            v.rs  = ($urandom_range(0, 3) == 0);
            run_vec(v, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
